mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between instruction fetch (IF) and data access (LDR/STR from EX/MEM).
- Serialises accesses, one outstanding at a time, with fixed memory read latency.
- Returns read data to the winning requester and produces the pipeline stall signal consumed by the fetch/decode stages.
- Sits between the pipeline stages and the memory macro.

Parameters:
ADDR_W, 16, address width of both requesters and memory port
DATA_W, 16, data width
MEM_LATENCY, 2, cycles from issue (o_mem_en=1) to valid i_mem_rdata; legal range 1..15

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
i_if_req  in  1  fetch request, held high until o_if_valid
i_if_addr  in  ADDR_W  fetch address, stable while i_if_req=1
o_if_rdata  out  DATA_W  fetched instruction
o_if_valid  out  1  one-cycle completion pulse for fetch
i_data_req  in  1  data request, held high until o_data_valid
i_data_we  in  1  1=store, 0=load
i_data_addr  in  ADDR_W  data address
i_data_wdata  in  DATA_W  store data
o_data_rdata  out  DATA_W  load data
o_data_valid  out  1  one-cycle completion pulse for data access
o_mem_en  out  1  memory access strobe, one cycle per access
o_mem_we  out  1  memory write enable
o_mem_addr  out  ADDR_W  memory address
o_mem_wdata  out  DATA_W  memory write data
i_mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after issue
o_stall  out  1  pipeline stall

Behaviour:
- Reset values: state IDLE, o_mem_en=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_if_rdata=0, o_data_rdata=0, both valids=0, latency counter=0, last-grant=IF.
- Reset mid-access abandons the access. i_mem_rdata from the abandoned access is ignored and no valid pulse is produced.
- FSM states: IDLE, WAIT, DONE. All outputs are registered except o_stall.
- IDLE:
  - If i_data_req=1: grant data.
  - Else if i_if_req=1: grant IF.
  - Else stay in IDLE.
  - On a grant, at the clock edge: o_mem_en<=1; o_mem_addr, o_mem_we and o_mem_wdata loaded from the winner (o_mem_we=0, o_mem_wdata unchanged for IF); counter<=MEM_LATENCY; state<=WAIT.
- WAIT:
  - o_mem_en=1 only in the first WAIT cycle (the issue cycle, I).
  - o_mem_we drops with o_mem_en. o_mem_addr and o_mem_wdata hold their values.
  - Counter decrements each cycle.
  - In the cycle where counter==0 (cycle I+MEM_LATENCY): capture i_mem_rdata into the winner's rdata register (loads and fetches only), set the winner's valid<=1, state<=DONE.
- DONE:
  - Winner's valid=1 for exactly this cycle (I+MEM_LATENCY+1).
  - No arbitration in DONE, so the still-high request is not regranted.
  - Next state IDLE.
- Stores:
  - i_mem_rdata is ignored; o_data_rdata holds its previous value.
  - o_data_valid still pulses.
- Latency: request seen in IDLE cycle R gives issue at R+1 and valid at R+2+MEM_LATENCY. Next grant decision at R+3+MEM_LATENCY.
- o_stall (combinational) = (i_data_req & ~o_data_valid) | (i_if_req & ~o_if_valid).
- Requests asserted while not in IDLE wait; no queueing beyond the held request lines.
- Simultaneous requests in IDLE: data wins (the in-flight instruction must complete before the next one enters).
- Counter is 4 bits. MEM_LATENCY outside 1..15 is a configuration error, flagged by an elaboration-time check.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: when both requests are pending in IDLE, grant the requester not served last (last-grant register updated on every grant). A single pending request is always granted. This prevents fetch starvation under back-to-back data traffic.
- Undefined: fixed priority, data over IF. The last-grant register is not built.

Test Plan:
- MEM_LATENCY=2, fetch only: i_if_req=1, i_if_addr=0x0010 from cycle 0; memory returns 0x2105 in cycle 3 -> o_mem_en=1, o_mem_addr=0x0010, o_mem_we=0 in cycle 1; o_if_valid=1, o_if_rdata=0x2105 in cycle 4 only.
- Both requests in cycle 0 (data load addr 0x0200 returns 0x1234, fetch addr 0x0012), macro off -> data issued cycle 1, o_data_valid cycle 4, o_data_rdata=0x1234; fetch issued cycle 6, o_if_valid cycle 9.
- Store addr 0x0100, wdata 0xBEEF, prior o_data_rdata=0x1234 -> cycle 1: o_mem_en=1, o_mem_we=1, o_mem_wdata=0xBEEF; o_data_valid cycle 4; o_data_rdata stays 0x1234.
- Stall: only i_data_req high from cycle 0 -> o_stall=1 cycles 0-3, o_stall=0 cycle 4, o_stall=0 after request drops in cycle 5.
- rst=1 in cycle 2 of a fetch -> cycle 3: o_mem_en=0, no o_if_valid pulse ever; new fetch requested in cycle 4 completes normally at cycle 8.
- Both requests held continuously for 20 cycles: macro off -> only data granted; MEM_ARB_RR_EN defined -> grants alternate data, IF, data, IF at issue cycles 1, 6, 11, 16.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access, one access in flight.
// Optional MEM_ARB_RR_EN: round-robin between simultaneous requests instead of data-first priority.
module mem_port_arbiter #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int MEM_LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic [DATA_W-1:0] o_if_rdata,
   output logic              o_if_valid,
   input  logic              i_data_req,
   input  logic              i_data_we,
   input  logic [ADDR_W-1:0] i_data_addr,
   input  logic [DATA_W-1:0] i_data_wdata,
   output logic [DATA_W-1:0] o_data_rdata,
   output logic              o_data_valid,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_stall
);

   generate
      if ((MEM_LATENCY < 1) || (MEM_LATENCY > 15)) begin : g_bad_latency
         $error("mem_port_arbiter: MEM_LATENCY must be in 1..15");
      end
   endgenerate

   localparam logic [3:0] LAT = 4'(MEM_LATENCY);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              win_data_q, win_data_d;
   logic              store_q, store_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
   logic              if_valid_q, if_valid_d;
   logic              data_valid_q, data_valid_d;
   logic              grant_data;

`ifdef MEM_ARB_RR_EN
   logic              last_data_q, last_data_d;

   // Data loses a tie only when it was the last one served.
   assign grant_data = i_data_req & (~i_if_req | ~last_data_q);
`else
   assign grant_data = i_data_req;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      win_data_d   = win_data_q;
      store_d      = store_q;
      mem_en_d     = 1'b0;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      if_rdata_d   = if_rdata_q;
      data_rdata_d = data_rdata_q;
      if_valid_d   = 1'b0;
      data_valid_d = 1'b0;
`ifdef MEM_ARB_RR_EN
      last_data_d  = last_data_q;
`endif
      case (state_q)
         IDLE: begin
            if (i_data_req | i_if_req) begin
               mem_en_d   = 1'b1;
               win_data_d = grant_data;
               cnt_d      = LAT;
               state_d    = WAIT;
`ifdef MEM_ARB_RR_EN
               last_data_d = grant_data;
`endif
               if (grant_data) begin
                  mem_we_d    = i_data_we;
                  store_d     = i_data_we;
                  mem_addr_d  = i_data_addr;
                  mem_wdata_d = i_data_wdata;
               end else begin
                  store_d     = 1'b0;
                  mem_addr_d  = i_if_addr;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = DONE;
               if (win_data_q) begin
                  data_valid_d = 1'b1;
                  // Stores leave the load-data register untouched.
                  if (!store_q) data_rdata_d = i_mem_rdata;
               end else begin
                  if_valid_d = 1'b1;
                  if_rdata_d = i_mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         win_data_q   <= 1'b0;
         store_q      <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         if_rdata_q   <= '0;
         data_rdata_q <= '0;
         if_valid_q   <= 1'b0;
         data_valid_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_data_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         win_data_q   <= win_data_d;
         store_q      <= store_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         if_rdata_q   <= if_rdata_d;
         data_rdata_q <= data_rdata_d;
         if_valid_q   <= if_valid_d;
         data_valid_q <= data_valid_d;
`ifdef MEM_ARB_RR_EN
         last_data_q  <= last_data_d;
`endif
      end
   end

   assign o_mem_en     = mem_en_q;
   assign o_mem_we     = mem_we_q;
   assign o_mem_addr   = mem_addr_q;
   assign o_mem_wdata  = mem_wdata_q;
   assign o_if_rdata   = if_rdata_q;
   assign o_if_valid   = if_valid_q;
   assign o_data_rdata = data_rdata_q;
   assign o_data_valid = data_valid_q;
   assign o_stall      = (i_data_req & ~data_valid_q) | (i_if_req & ~if_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a random run against a transaction-level model.
// Build with MEM_ARB_RR_EN defined to check the round-robin variant.
module tb_mem_port_arbiter;
   localparam int AW = 16;
   localparam int DW = 16;
   localparam int L  = 2;
`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          i_if_req;
   logic [AW-1:0] i_if_addr;
   logic [DW-1:0] o_if_rdata;
   logic          o_if_valid;
   logic          i_data_req;
   logic          i_data_we;
   logic [AW-1:0] i_data_addr;
   logic [DW-1:0] i_data_wdata;
   logic [DW-1:0] o_data_rdata;
   logic          o_data_valid;
   logic          o_mem_en;
   logic          o_mem_we;
   logic [AW-1:0] o_mem_addr;
   logic [DW-1:0] o_mem_wdata;
   logic [DW-1:0] i_mem_rdata;
   logic          o_stall;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [DW-1:0] mem     [logic [AW-1:0]];
   logic [DW-1:0] ref_mem [logic [AW-1:0]];

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(L)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_if_req     (i_if_req),
      .i_if_addr    (i_if_addr),
      .o_if_rdata   (o_if_rdata),
      .o_if_valid   (o_if_valid),
      .i_data_req   (i_data_req),
      .i_data_we    (i_data_we),
      .i_data_addr  (i_data_addr),
      .i_data_wdata (i_data_wdata),
      .o_data_rdata (o_data_rdata),
      .o_data_valid (o_data_valid),
      .o_mem_en     (o_mem_en),
      .o_mem_we     (o_mem_we),
      .o_mem_addr   (o_mem_addr),
      .o_mem_wdata  (o_mem_wdata),
      .i_mem_rdata  (i_mem_rdata),
      .o_stall      (o_stall)
   );

   function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
      return mem.exists(a) ? mem[a] : '0;
   endfunction

   // Memory macro: data appears L cycles after the issue cycle, random noise otherwise.
   initial begin : responder
      int            cnt;
      logic [AW-1:0] ra;
      logic          rwe;
      cnt = 0;
      ra  = '0;
      rwe = 1'b0;
      i_mem_rdata = '0;
      forever begin
         @(negedge clk);
         i_mem_rdata = 16'($urandom);
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0 && !rwe) i_mem_rdata = mem_rd(ra);
         end
         if (o_mem_en === 1'b1) begin
            cnt = L;
            ra  = o_mem_addr;
            rwe = o_mem_we;
            if (o_mem_we) mem[ra] = o_mem_wdata;
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      i_if_req = 1'b0;     i_if_addr = '0;
      i_data_req = 1'b0;   i_data_we = 1'b0;
      i_data_addr = '0;    i_data_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int c = 0; c <= 3; c++) begin
         i_data_req = (c <= 1);  i_data_we = 1'b1;
         i_data_addr = 16'h0100; i_data_wdata = 16'hBEEF;
         rst = (c == 2);
         #1;
         if (c == 3) begin
            checks++;
            if ({o_mem_en, o_mem_we, o_if_valid, o_data_valid, o_stall} !== 5'b0) begin
               errors++;
               $display("FAIL reset_ctrl got en/we/ifv/dv/stall=%b required 00000",
                        {o_mem_en, o_mem_we, o_if_valid, o_data_valid, o_stall});
            end
            checks++;
            if (o_mem_addr !== 16'h0 || o_mem_wdata !== 16'h0) begin
               errors++;
               $display("FAIL reset_mem got addr=%h wdata=%h required 0000 0000", o_mem_addr, o_mem_wdata);
            end
            checks++;
            if (o_if_rdata !== 16'h0 || o_data_rdata !== 16'h0) begin
               errors++;
               $display("FAIL reset_rdata got if=%h data=%h required 0000 0000", o_if_rdata, o_data_rdata);
            end
         end
         next_cycle();
      end
      rst = 1'b0;
   endtask

   task automatic test_fetch();
      do_reset();
      mem[16'h0010] = 16'h2105;
      for (int c = 0; c <= 5; c++) begin
         i_if_req = (c <= 4); i_if_addr = 16'h0010;
         #1;
         checks++;
         if (o_mem_en !== (c == 1)) begin
            errors++; $display("FAIL fetch_en c=%0d got=%b required=%b", c, o_mem_en, (c == 1));
         end
         if (c == 1) begin
            checks++;
            if (o_mem_addr !== 16'h0010 || o_mem_we !== 1'b0) begin
               errors++; $display("FAIL fetch_issue got addr=%h we=%b required 0010 0", o_mem_addr, o_mem_we);
            end
         end
         checks++;
         if (o_if_valid !== (c == 4)) begin
            errors++; $display("FAIL fetch_valid c=%0d got=%b required=%b", c, o_if_valid, (c == 4));
         end
         if (c == 4) begin
            checks++;
            if (o_if_rdata !== 16'h2105) begin
               errors++; $display("FAIL fetch_rdata got=%h required=2105", o_if_rdata);
            end
         end
         next_cycle();
      end
      i_if_req = 1'b0;
   endtask

   task automatic test_priority();
      do_reset();
      mem[16'h0200] = 16'h1234;
      mem[16'h0012] = 16'h5A5A;
      for (int c = 0; c <= 10; c++) begin
         i_data_req = (c <= 4); i_data_we = 1'b0; i_data_addr = 16'h0200;
         i_if_req   = (c <= 9); i_if_addr = 16'h0012;
         #1;
         checks++;
         if (o_mem_en !== (c == 1 || c == 6)) begin
            errors++; $display("FAIL prio_en c=%0d got=%b required=%b", c, o_mem_en, (c == 1 || c == 6));
         end
         if (c == 1 || c == 6) begin
            checks++;
            if (o_mem_addr !== ((c == 1) ? 16'h0200 : 16'h0012)) begin
               errors++; $display("FAIL prio_addr c=%0d got=%h", c, o_mem_addr);
            end
         end
         checks++;
         if (o_data_valid !== (c == 4) || o_if_valid !== (c == 9)) begin
            errors++; $display("FAIL prio_valid c=%0d got dv=%b ifv=%b required dv=%b ifv=%b",
                               c, o_data_valid, o_if_valid, (c == 4), (c == 9));
         end
         if (c == 4) begin
            checks++;
            if (o_data_rdata !== 16'h1234) begin
               errors++; $display("FAIL prio_drdata got=%h required=1234", o_data_rdata);
            end
         end
         if (c == 9) begin
            checks++;
            if (o_if_rdata !== 16'h5A5A) begin
               errors++; $display("FAIL prio_ifrdata got=%h required=5a5a", o_if_rdata);
            end
         end
         next_cycle();
      end
      i_data_req = 1'b0; i_if_req = 1'b0;
   endtask

   // Runs straight after test_priority so the load-data register already holds 0x1234.
   task automatic test_store();
      cyc = 0;
      for (int c = 0; c <= 5; c++) begin
         i_data_req = (c <= 4); i_data_we = 1'b1;
         i_data_addr = 16'h0100; i_data_wdata = 16'hBEEF;
         #1;
         checks++;
         if (o_mem_en !== (c == 1) || o_mem_we !== (c == 1)) begin
            errors++; $display("FAIL store_en c=%0d got en=%b we=%b required=%b", c, o_mem_en, o_mem_we, (c == 1));
         end
         if (c == 1 || c == 2) begin
            checks++;
            if (o_mem_addr !== 16'h0100 || o_mem_wdata !== 16'hBEEF) begin
               errors++; $display("FAIL store_bus c=%0d got addr=%h wdata=%h required 0100 beef",
                                  c, o_mem_addr, o_mem_wdata);
            end
         end
         checks++;
         if (o_data_valid !== (c == 4)) begin
            errors++; $display("FAIL store_valid c=%0d got=%b required=%b", c, o_data_valid, (c == 4));
         end
         checks++;
         if (o_data_rdata !== 16'h1234) begin
            errors++; $display("FAIL store_rdata_hold c=%0d got=%h required=1234", c, o_data_rdata);
         end
         next_cycle();
      end
      i_data_req = 1'b0; i_data_we = 1'b0;
   endtask

   task automatic test_stall();
      do_reset();
      for (int c = 0; c <= 5; c++) begin
         i_data_req = (c <= 4); i_data_we = 1'b0; i_data_addr = 16'h0200;
         #1;
         checks++;
         if (o_stall !== (c <= 3)) begin
            errors++; $display("FAIL stall c=%0d got=%b required=%b", c, o_stall, (c <= 3));
         end
         next_cycle();
      end
      i_data_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int c = 0; c <= 9; c++) begin
         i_if_req  = (c <= 1) || (c >= 4 && c <= 8);
         i_if_addr = 16'h0010;
         rst       = (c == 2);
         #1;
         checks++;
         if (o_mem_en !== (c == 1 || c == 5)) begin
            errors++; $display("FAIL rstmid_en c=%0d got=%b required=%b", c, o_mem_en, (c == 1 || c == 5));
         end
         checks++;
         if (o_if_valid !== (c == 8)) begin
            errors++; $display("FAIL rstmid_valid c=%0d got=%b required=%b", c, o_if_valid, (c == 8));
         end
         if (c == 8) begin
            checks++;
            if (o_if_rdata !== 16'h2105) begin
               errors++; $display("FAIL rstmid_rdata got=%h required=2105", o_if_rdata);
            end
         end
         next_cycle();
      end
      rst = 1'b0; i_if_req = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] exp_addr;
      logic          exp_ifv;
      do_reset();
      for (int c = 0; c <= 24; c++) begin
         i_data_req = (c <= 19); i_data_we = 1'b0; i_data_addr = 16'h0200;
         i_if_req   = (c <= 19); i_if_addr = 16'h0012;
         #1;
         checks++;
         if (o_mem_en !== (c % 5 == 1 && c <= 16)) begin
            errors++; $display("FAIL b2b_en c=%0d got=%b required=%b", c, o_mem_en, (c % 5 == 1 && c <= 16));
         end
         if (c % 5 == 1 && c <= 16) begin
            exp_addr = (RR && ((c - 1) / 5) % 2 == 1) ? 16'h0012 : 16'h0200;
            checks++;
            if (o_mem_addr !== exp_addr) begin
               errors++; $display("FAIL b2b_grant c=%0d got addr=%h required=%h", c, o_mem_addr, exp_addr);
            end
         end
         exp_ifv = RR && (c == 9 || c == 19);
         checks++;
         if (o_if_valid !== exp_ifv) begin
            errors++; $display("FAIL b2b_ifvalid c=%0d got=%b required=%b", c, o_if_valid, exp_ifv);
         end
         next_cycle();
      end
      i_data_req = 1'b0; i_if_req = 1'b0;
   endtask

   // Transaction-level model: a grant at cycle c occupies the port until c+L+3.
   task automatic test_random();
      int            iss_c, val_c, free_c, ntx;
      bit            win_data, win_we, last_data, pick, drop_if, drop_d;
      logic [AW-1:0] w_addr;
      logic [DW-1:0] w_wdata, pend_rd, exp_if_rd, exp_d_rd;
      logic          exp_ifv, exp_dv;
      do_reset();
      for (int a = 0; a < 8; a++) begin
         w_wdata = 16'($urandom);
         mem[16'h0300 + 16'(a)]     = w_wdata;
         ref_mem[16'h0300 + 16'(a)] = w_wdata;
      end
      iss_c = -100; val_c = -100; free_c = 0; ntx = 0;
      win_data = 1'b0; win_we = 1'b0; last_data = 1'b0;
      w_addr = '0; w_wdata = '0; pend_rd = '0; exp_if_rd = '0; exp_d_rd = '0;
      for (int c = 0; c < 600; c++) begin
         drop_if = 1'b0; drop_d = 1'b0;
         if (c == val_c + 1) begin
            if (win_data) begin i_data_req = 1'b0; drop_d = 1'b1; end
            else          begin i_if_req   = 1'b0; drop_if = 1'b1; end
         end
         if (!i_if_req && !drop_if && $urandom_range(0, 2) == 0) begin
            i_if_req  = 1'b1;
            i_if_addr = 16'h0300 + 16'($urandom_range(0, 7));
         end
         if (!i_data_req && !drop_d && $urandom_range(0, 2) == 0) begin
            i_data_req   = 1'b1;
            i_data_we    = 1'($urandom_range(0, 1));
            i_data_addr  = 16'h0300 + 16'($urandom_range(0, 7));
            i_data_wdata = 16'($urandom);
         end
         if (c >= free_c && (i_data_req || i_if_req)) begin
            pick      = RR ? (i_data_req && (!i_if_req || !last_data)) : i_data_req;
            last_data = pick;
            win_data  = pick;
            iss_c = c + 1; val_c = c + L + 2; free_c = c + L + 3;
            if (pick) begin
               w_addr = i_data_addr; win_we = i_data_we; w_wdata = i_data_wdata;
               if (win_we) ref_mem[w_addr] = w_wdata;
               else        pend_rd = ref_mem[w_addr];
            end else begin
               w_addr = i_if_addr; win_we = 1'b0;
               pend_rd = ref_mem[w_addr];
            end
         end
         exp_ifv = (c == val_c) && !win_data;
         exp_dv  = (c == val_c) && win_data;
         if (exp_ifv) exp_if_rd = pend_rd;
         if (exp_dv && !win_we) exp_d_rd = pend_rd;
         #1;
         checks++;
         if (o_mem_en !== (c == iss_c)) begin
            errors++; $display("FAIL rnd_en c=%0d got=%b required=%b", c, o_mem_en, (c == iss_c));
         end
         if (c == iss_c) begin
            checks++;
            if (o_mem_addr !== w_addr || o_mem_we !== win_we || (win_we && o_mem_wdata !== w_wdata)) begin
               errors++; $display("FAIL rnd_issue c=%0d got addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
                                  c, o_mem_addr, o_mem_we, o_mem_wdata, w_addr, win_we, w_wdata);
            end
         end
         checks++;
         if (o_if_valid !== exp_ifv || o_data_valid !== exp_dv) begin
            errors++; $display("FAIL rnd_valid c=%0d got ifv=%b dv=%b required ifv=%b dv=%b",
                               c, o_if_valid, o_data_valid, exp_ifv, exp_dv);
         end
         checks++;
         if (o_if_rdata !== exp_if_rd || o_data_rdata !== exp_d_rd) begin
            errors++; $display("FAIL rnd_rdata c=%0d got if=%h data=%h required if=%h data=%h",
                               c, o_if_rdata, o_data_rdata, exp_if_rd, exp_d_rd);
         end
         checks++;
         if (o_stall !== ((i_data_req & ~exp_dv) | (i_if_req & ~exp_ifv))) begin
            errors++; $display("FAIL rnd_stall c=%0d got=%b required=%b", c, o_stall,
                               ((i_data_req & ~exp_dv) | (i_if_req & ~exp_ifv)));
         end
         if (c == val_c) begin
            ntx++;
            $display("txn %0d c=%0d %s addr=%h we=%b data=%h", ntx, c, win_data ? "DATA" : "IF  ",
                     w_addr, win_we, win_we ? w_wdata : pend_rd);
         end
         next_cycle();
      end
      i_if_req = 1'b0; i_data_req = 1'b0;
      repeat (L + 4) next_cycle();
   endtask

   initial begin
      rst = 1'b1;
      i_if_req = 1'b0;   i_if_addr = '0;
      i_data_req = 1'b0; i_data_we = 1'b0;
      i_data_addr = '0;  i_data_wdata = '0;
      test_reset();
      test_fetch();
      test_priority();
      test_store();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
